// File: rtl/fft_pack.sv
`default_nettype none
// ============================================================================
// Module      : fft_pack
// Description : Collects 16 FFT bins (16-bit re/im each) into a fill bank.
//               When a well-formed frame completes, it loads all 16 packed
//               words ({re,im}) into the output registers at once.
//               Malformed frames (bin_last misplaced or missing) are
//               discarded and reported with a one-cycle frame_err pulse.
//               Optional macro FFT_PACK_BITREV_EN: when defined, beat k is
//               stored in slot bitrev4(k), so radix-2 output order becomes
//               natural order. When undefined, slot = k.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        bin_valid,
    input  logic        bin_last,
    input  logic [15:0] bin_re,
    input  logic [15:0] bin_im,
    output logic        fft_valid,
    output logic [31:0] fft_d0,
    output logic [31:0] fft_d1,
    output logic [31:0] fft_d2,
    output logic [31:0] fft_d3,
    output logic [31:0] fft_d4,
    output logic [31:0] fft_d5,
    output logic [31:0] fft_d6,
    output logic [31:0] fft_d7,
    output logic [31:0] fft_d8,
    output logic [31:0] fft_d9,
    output logic [31:0] fft_d10,
    output logic [31:0] fft_d11,
    output logic [31:0] fft_d12,
    output logic [31:0] fft_d13,
    output logic [31:0] fft_d14,
    output logic [31:0] fft_d15,
    output logic        frame_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FILL = 2'd1;
    localparam logic [1:0] c_EMIT = 2'd2;

    localparam logic [3:0] c_LAST_BEAT = 4'd15;

    // Map a beat number to its storage slot.
    function automatic logic [3:0] f_slot(input logic [3:0] k);
`ifdef FFT_PACK_BITREV_EN
        f_slot = {k[0], k[1], k[2], k[3]};
`else
        f_slot = k;
`endif
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_frame_err;
    logic [31:0] r_bank  [16];
    logic [31:0] r_fft_d [16];

    logic [31:0] w_bin;
    logic [3:0]  w_slot;
    logic        w_at_last_beat;
    logic        w_emit;
    logic        w_err;

    assign w_bin          = {bin_re, bin_im};
    assign w_slot         = f_slot(r_cnt);
    assign w_at_last_beat = (r_cnt == c_LAST_BEAT);
    // A frame completes only when the 16th beat carries bin_last; any other
    // placement (or absence) of bin_last on the 16th beat is a framing error.
    assign w_emit         = bin_valid & bin_last & w_at_last_beat;
    assign w_err          = bin_valid & (bin_last ^ w_at_last_beat);

    // Next-state selection: accepted beats drive every transition, EMIT
    // falls back to IDLE after its single cycle when no beat arrives.
    always_comb begin
        w_state_nxt = r_state;
        if (bin_valid) begin
            if (w_emit) begin
                w_state_nxt = c_EMIT;
            end else if (w_err) begin
                w_state_nxt = c_IDLE;
            end else begin
                w_state_nxt = c_FILL;
            end
        end else if (r_state == c_EMIT) begin
            w_state_nxt = c_IDLE;
        end
    end

    // State register, beat counter and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= 4'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_err <= w_err;
            if (bin_valid) begin
                if (w_emit || w_err) begin
                    r_cnt <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

    // Fill bank: store each non-final beat in its mapped slot (no reset needed,
    // every slot is rewritten before it can reach the outputs).
    always_ff @(posedge clk) begin
        if (bin_valid && !w_at_last_beat) begin
            r_bank[w_slot] <= w_bin;
        end
    end

    // Output registers: load the whole frame at once, bypassing the final
    // beat straight from the input so no extra cycle is spent banking it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_fft_d[i] <= 32'h0;
            end
        end else if (w_emit) begin
            for (int i = 0; i < 16; i++) begin
                if (4'(i) == w_slot) begin
                    r_fft_d[i] <= w_bin;
                end else begin
                    r_fft_d[i] <= r_bank[i];
                end
            end
        end
    end

    assign fft_valid = (r_state == c_EMIT);
    assign frame_err = r_frame_err;

    assign fft_d0  = r_fft_d[0];
    assign fft_d1  = r_fft_d[1];
    assign fft_d2  = r_fft_d[2];
    assign fft_d3  = r_fft_d[3];
    assign fft_d4  = r_fft_d[4];
    assign fft_d5  = r_fft_d[5];
    assign fft_d6  = r_fft_d[6];
    assign fft_d7  = r_fft_d[7];
    assign fft_d8  = r_fft_d[8];
    assign fft_d9  = r_fft_d[9];
    assign fft_d10 = r_fft_d[10];
    assign fft_d11 = r_fft_d[11];
    assign fft_d12 = r_fft_d[12];
    assign fft_d13 = r_fft_d[13];
    assign fft_d14 = r_fft_d[14];
    assign fft_d15 = r_fft_d[15];

endmodule
`default_nettype wire

// File: tb/tb_fft_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_pack
// Description : Self-checking bench for fft_pack. A frame-level reference
//               model (queue of received bins, emitted as a whole frame)
//               predicts fft_valid, frame_err and all 16 outputs each cycle.
//               Honours FFT_PACK_BITREV_EN when defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bin_valid = 1'b0;
    logic        bin_last = 1'b0;
    logic [15:0] bin_re = 16'h0;
    logic [15:0] bin_im = 16'h0;
    logic        fft_valid;
    logic        frame_err;
    logic [31:0] d_obs [16];

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model state
    logic [31:0] m_q [$];
    logic [31:0] m_out [16];
    logic        m_valid;
    logic        m_err;

    always #5 clk = ~clk;

    fft_pack u_dut (
        .clk       (clk),
        .rst       (rst),
        .bin_valid (bin_valid),
        .bin_last  (bin_last),
        .bin_re    (bin_re),
        .bin_im    (bin_im),
        .fft_valid (fft_valid),
        .fft_d0    (d_obs[0]),
        .fft_d1    (d_obs[1]),
        .fft_d2    (d_obs[2]),
        .fft_d3    (d_obs[3]),
        .fft_d4    (d_obs[4]),
        .fft_d5    (d_obs[5]),
        .fft_d6    (d_obs[6]),
        .fft_d7    (d_obs[7]),
        .fft_d8    (d_obs[8]),
        .fft_d9    (d_obs[9]),
        .fft_d10   (d_obs[10]),
        .fft_d11   (d_obs[11]),
        .fft_d12   (d_obs[12]),
        .fft_d13   (d_obs[13]),
        .fft_d14   (d_obs[14]),
        .fft_d15   (d_obs[15]),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Where beat k lands in the output frame.
    function automatic int slot_of(input int k);
        int r;
`ifdef FFT_PACK_BITREV_EN
        r = 0;
        for (int b = 0; b < 4; b++) begin
            if (((k >> b) & 1) == 1) r = r + (1 << (3 - b));
        end
`else
        r = k;
`endif
        return r;
    endfunction

    // One clock: drive inputs, advance the model, compare everything.
    task automatic step(input bit r, input bit v, input bit l,
                        input logic [15:0] re, input logic [15:0] im);
        logic [31:0] w;
        @(negedge clk);
        rst = r; bin_valid = v; bin_last = l; bin_re = re; bin_im = im;
        @(posedge clk);
        m_valid = 1'b0;
        m_err   = 1'b0;
        w = {re, im};
        if (r) begin
            m_q.delete();
            for (int i = 0; i < 16; i++) m_out[i] = 32'h0;
        end else if (v) begin
            if (l && m_q.size() == 15) begin
                m_q.push_back(w);
                for (int i = 0; i < 16; i++) m_out[slot_of(i)] = m_q[i];
                m_q.delete();
                m_valid = 1'b1;
            end else if (l || m_q.size() == 15) begin
                m_q.delete();
                m_err = 1'b1;
            end else begin
                m_q.push_back(w);
            end
        end
        #1;
        check("fft_valid", {31'h0, fft_valid}, {31'h0, m_valid});
        check("frame_err", {31'h0, frame_err}, {31'h0, m_err});
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fft_d%0d", i), d_obs[i], m_out[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Send n beats; bin_last on beat last_at (-1: never). pat selects the
    // re=k / im=-k pattern, otherwise random data. gaps inserts random idle
    // cycles before every beat except the first.
    task automatic send_frame(input int n, input int last_at, input bit gaps, input bit pat);
        logic [15:0] re;
        logic [15:0] im;
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) idle($urandom_range(0, 3));
            if (pat) begin
                re = 16'(k);
                im = 16'(0 - k);
            end else begin
                re = 16'($urandom);
                im = 16'($urandom);
            end
            step(1'b0, 1'b1, (k == last_at), re, im);
        end
    endtask

    initial begin
        m_valid = 1'b0;
        m_err   = 1'b0;
        for (int i = 0; i < 16; i++) m_out[i] = 32'h0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678);
        idle(2);

        // Contiguous ramp frame; the last step call samples the EMIT cycle
        send_frame(16, 15, 1'b0, 1'b1);
`ifdef FFT_PACK_BITREV_EN
        check("ramp_d8", d_obs[8], 32'h0001FFFF);
        check("ramp_d1", d_obs[1], 32'h0008FFF8);
`else
        check("ramp_d5", d_obs[5], 32'h0005FFFB);
`endif
        check("ramp_valid", {31'h0, fft_valid}, 32'h1);
        idle(2);

        // bin_last on beat 7: error, outputs retained, then a clean frame
        send_frame(8, 7, 1'b0, 1'b0);
        idle(2);
        send_frame(16, 15, 1'b1, 1'b0);
        idle(1);

        // 16 beats and no bin_last: error after beat 15
        send_frame(16, -1, 1'b0, 1'b0);
        idle(2);

        // Back-to-back: next frame's beat 0 lands on the EMIT cycle
        send_frame(16, 15, 1'b0, 1'b0);
        send_frame(16, 15, 1'b1, 1'b0);
        idle(2);

        // Reset after 9 beats, then a full frame with no stale data
        send_frame(9, -1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        send_frame(16, 15, 1'b1, 1'b0);
        idle(2);

        // Random mix of clean and malformed frames
        for (int f = 0; f < 30; f++) begin
            int kind;
            int j;
            kind = $urandom_range(0, 9);
            if (kind < 7) begin
                send_frame(16, 15, 1'b1, 1'b0);
            end else if (kind < 9) begin
                j = $urandom_range(0, 14);
                send_frame(j + 1, j, 1'b1, 1'b0);
            end else begin
                send_frame(16, -1, 1'b1, 1'b0);
            end
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
